// File: rtl/video_pattern_gen.sv
// Programmable video timing plus test-pattern source; outputs are registered one cycle after counter state.
// Define VPG_AUTO_CYCLE_EN to ignore mode and step through patterns 0..9 every FRAMES_PER_MODE frames.
module video_pattern_gen #(
   parameter int BPC             = 8,
   parameter int HW              = 12,
   parameter int VW              = 11,
   parameter int BAR_W           = 16,
   parameter int FRAMES_PER_MODE = 60
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [3:0]       mode,
   input  logic [HW-1:0]    h_active,
   input  logic [HW-1:0]    h_front,
   input  logic [HW-1:0]    h_sync,
   input  logic [HW-1:0]    h_back,
   input  logic [VW-1:0]    v_active,
   input  logic [VW-1:0]    v_front,
   input  logic [VW-1:0]    v_sync,
   input  logic [VW-1:0]    v_back,
   output logic             o_hsync_n,
   output logic             o_vsync_n,
   output logic             o_de,
   output logic [3*BPC-1:0] o_data,
   output logic             o_frame_start,
   output logic             o_cfg_err
);

   localparam int HT   = HW + 2;
   localparam int VT   = VW + 2;
   localparam int DW   = 3 * BPC;
   localparam int GREP = (BPC + 2) / 3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [HT-1:0] pix_q, pix_d;
   logic [VT-1:0] line_q, line_d;
   logic          err_q, err_d;
   logic [HW-1:0] off_q, off_d;

   logic [HW-1:0] sh_hact_q, sh_hfp_q, sh_hsync_q, sh_hbp_q;
   logic [VW-1:0] sh_vact_q, sh_vfp_q, sh_vsync_q, sh_vbp_q;

   logic [2:0]    col_q, col_d, row_q, row_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;

   logic          hsync_n_q, vsync_n_q, de_q, fs_q;
   logic [DW-1:0] data_q;

   logic [HT-1:0] htot, hstart, hend;
   logic [VT-1:0] vtot, vstart, vend;
   logic [HW-1:0] hband, ax, bar_pos, off_inc;
   logic [VW-1:0] vband, ay;
   logic          cfg_ok, pix_last, frame_last, in_h, in_v, de_c;
   logic          load, run_start, frame_wrap;
   logic [3:0]    pat_sel;
   logic [DW-1:0] pat_dat;

   function automatic logic [DW-1:0] rgb(input logic [2:0] c);
      return {{BPC{c[2]}}, {BPC{c[1]}}, {BPC{c[0]}}};
   endfunction

   // 3-bit level repeated MSB-first so that 7 maps to full scale at any BPC
   function automatic logic [BPC-1:0] gray_lvl(input logic [2:0] v);
      logic [3*GREP-1:0] rep;
      rep = {GREP{v}};
      return rep[3*GREP-1 -: BPC];
   endfunction

   function automatic logic [2:0] bar_rgb(input logic [2:0] c);
      logic [2:0] r;
      case (c)
         3'd0:    r = 3'b111;
         3'd1:    r = 3'b110;
         3'd2:    r = 3'b011;
         3'd3:    r = 3'b010;
         3'd4:    r = 3'b101;
         3'd5:    r = 3'b100;
         3'd6:    r = 3'b001;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   always_comb begin
      hstart = HT'(sh_hsync_q) + HT'(sh_hbp_q);
      hend   = hstart + HT'(sh_hact_q);
      htot   = hend + HT'(sh_hfp_q);
      vstart = VT'(sh_vsync_q) + VT'(sh_vbp_q);
      vend   = vstart + VT'(sh_vact_q);
      vtot   = vend + VT'(sh_vfp_q);
   end

   assign cfg_ok     = (h_active >= HW'(8)) && (v_active >= VW'(8)) &&
                       (h_sync != '0) && (v_sync != '0);
   assign pix_last   = (pix_q == htot - HT'(1));
   assign frame_last = pix_last && (line_q == vtot - VT'(1));
   assign in_h       = (pix_q >= hstart) && (pix_q < hend);
   assign in_v       = (line_q >= vstart) && (line_q < vend);
   assign de_c       = (state_q == ST_RUN) && in_h && in_v;
   assign run_start  = (state_q == ST_IDLE) && enable && cfg_ok;
   assign frame_wrap = (state_q == ST_RUN) && frame_last && enable && cfg_ok;
   assign load       = run_start || frame_wrap;
   assign off_inc    = off_q + HW'(1);

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      line_d  = line_q;
      err_d   = err_q;
      off_d   = off_q;
      case (state_q)
         ST_IDLE: begin
            pix_d  = '0;
            line_d = '0;
            if (enable) begin
               if (cfg_ok) begin
                  state_d = ST_RUN;
                  err_d   = 1'b0;
                  off_d   = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (frame_last) begin
               pix_d  = '0;
               line_d = '0;
               if (!enable) begin
                  state_d = ST_IDLE;
               end else if (cfg_ok) begin
                  err_d = 1'b0;
                  off_d = (off_inc >= h_active) ? '0 : off_inc;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end else if (pix_last) begin
               pix_d  = '0;
               line_d = line_q + VT'(1);
            end else begin
               pix_d = pix_q + HT'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Band indices step every active/8 pixels (lines) and stick at 7 to absorb the remainder
   assign hband = sh_hact_q >> 3;
   assign vband = sh_vact_q >> 3;

   always_comb begin
      col_d  = col_q;
      hcnt_d = hcnt_q;
      row_d  = row_q;
      vcnt_d = vcnt_q;
      if (!de_c) begin
         col_d  = '0;
         hcnt_d = '0;
      end else if (col_q != 3'd7) begin
         if (hcnt_q == hband - HW'(1)) begin
            col_d  = col_q + 3'd1;
            hcnt_d = '0;
         end else begin
            hcnt_d = hcnt_q + HW'(1);
         end
      end
      if (state_q != ST_RUN) begin
         row_d  = '0;
         vcnt_d = '0;
      end else if (pix_last) begin
         if (!in_v) begin
            row_d  = '0;
            vcnt_d = '0;
         end else if (row_q != 3'd7) begin
            if (vcnt_q == vband - VW'(1)) begin
               row_d  = row_q + 3'd1;
               vcnt_d = '0;
            end else begin
               vcnt_d = vcnt_q + VW'(1);
            end
         end
      end
   end

`ifdef VPG_AUTO_CYCLE_EN
   localparam int FCW = $clog2(FRAMES_PER_MODE + 1);
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic [3:0]     pat_q, pat_d;

   always_comb begin
      fcnt_d = fcnt_q;
      pat_d  = pat_q;
      if (run_start) begin
         fcnt_d = '0;
         pat_d  = '0;
      end else if (frame_wrap) begin
         if (fcnt_q == FCW'(FRAMES_PER_MODE - 1)) begin
            fcnt_d = '0;
            pat_d  = (pat_q == 4'd9) ? 4'd0 : pat_q + 4'd1;
         end else begin
            fcnt_d = fcnt_q + FCW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fcnt_q <= '0;
         pat_q  <= '0;
      end else begin
         fcnt_q <= fcnt_d;
         pat_q  <= pat_d;
      end
   end

   assign pat_sel = pat_q;
`else
   logic [3:0] sh_mode_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_mode_q <= '0;
      end else if (load) begin
         sh_mode_q <= mode;
      end
   end

   assign pat_sel = sh_mode_q;
`endif

   assign ax      = HW'(pix_q - hstart);
   assign ay      = VW'(line_q - vstart);
   // (ax - offset) mod h_active without a divider: both operands already lie in [0, h_active)
   assign bar_pos = (ax >= off_q) ? (ax - off_q) : (ax + sh_hact_q - off_q);

   always_comb begin
      pat_dat = '0;
      case (pat_sel)
         4'd0: pat_dat = rgb(3'b100);
         4'd1: pat_dat = rgb(3'b010);
         4'd2: pat_dat = rgb(3'b001);
         4'd3: pat_dat = '0;
         4'd4: pat_dat = rgb(3'b111);
         4'd5: pat_dat = {3{gray_lvl(3'd7 - col_q)}};
         4'd6: pat_dat = rgb({3{col_q[0] ^ row_q[0]}});
         4'd7: pat_dat = rgb(bar_rgb(col_q));
         4'd8: begin
            if ((ax == '0) || (ax == sh_hact_q - HW'(1)) ||
                (ay == '0) || (ay == sh_vact_q - VW'(1))) begin
               pat_dat = rgb(3'b111);
            end
         end
         4'd9: begin
            if (32'(bar_pos) < 32'(BAR_W)) begin
               pat_dat = rgb(3'b111);
            end
         end
         default: pat_dat = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         pix_q      <= '0;
         line_q     <= '0;
         err_q      <= 1'b0;
         off_q      <= '0;
         col_q      <= '0;
         hcnt_q     <= '0;
         row_q      <= '0;
         vcnt_q     <= '0;
         sh_hact_q  <= '0;
         sh_hfp_q   <= '0;
         sh_hsync_q <= '0;
         sh_hbp_q   <= '0;
         sh_vact_q  <= '0;
         sh_vfp_q   <= '0;
         sh_vsync_q <= '0;
         sh_vbp_q   <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         line_q  <= line_d;
         err_q   <= err_d;
         off_q   <= off_d;
         col_q   <= col_d;
         hcnt_q  <= hcnt_d;
         row_q   <= row_d;
         vcnt_q  <= vcnt_d;
         if (load) begin
            sh_hact_q  <= h_active;
            sh_hfp_q   <= h_front;
            sh_hsync_q <= h_sync;
            sh_hbp_q   <= h_back;
            sh_vact_q  <= v_active;
            sh_vfp_q   <= v_front;
            sh_vsync_q <= v_sync;
            sh_vbp_q   <= v_back;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync_n_q <= 1'b1;
         vsync_n_q <= 1'b1;
         de_q      <= 1'b0;
         data_q    <= '0;
         fs_q      <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         hsync_n_q <= 1'b1;
         vsync_n_q <= 1'b1;
         de_q      <= 1'b0;
         data_q    <= '0;
         fs_q      <= 1'b0;
      end else begin
         hsync_n_q <= (pix_q >= HT'(sh_hsync_q));
         vsync_n_q <= (line_q >= VT'(sh_vsync_q));
         de_q      <= de_c;
         data_q    <= de_c ? pat_dat : '0;
         fs_q      <= (pix_q == '0) && (line_q == '0);
      end
   end

   assign o_hsync_n     = hsync_n_q;
   assign o_vsync_n     = vsync_n_q;
   assign o_de          = de_q;
   assign o_data        = data_q;
   assign o_frame_start = fs_q;
   assign o_cfg_err     = err_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: directed timing scenarios plus randomized configs against a frame-level model.
module tb_video_pattern_gen;

   localparam int BPC   = 8;
   localparam int HW    = 12;
   localparam int VW    = 11;
   localparam int BAR_W = 16;
   localparam int FPM   = 60;
   localparam int FULL  = (1 << BPC) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic [3:0]       mode = '0;
   logic [HW-1:0]    h_active = '0, h_front = '0, h_sync = '0, h_back = '0;
   logic [VW-1:0]    v_active = '0, v_front = '0, v_sync = '0, v_back = '0;
   logic             o_hsync_n, o_vsync_n, o_de, o_frame_start, o_cfg_err;
   logic [3*BPC-1:0] o_data;

   video_pattern_gen #(.BPC(BPC), .HW(HW), .VW(VW), .BAR_W(BAR_W), .FRAMES_PER_MODE(FPM)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .h_active(h_active), .h_front(h_front), .h_sync(h_sync), .h_back(h_back),
      .v_active(v_active), .v_front(v_front), .v_sync(v_sync), .v_back(v_back),
      .o_hsync_n(o_hsync_n), .o_vsync_n(o_vsync_n), .o_de(o_de), .o_data(o_data),
      .o_frame_start(o_frame_start), .o_cfg_err(o_cfg_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: counters describe the pixel the DUT is currently processing
   int m_run, m_pix, m_line, m_err, m_off, m_pat, m_fcnt;
   int s_ha, s_hf, s_hs, s_hb, s_va, s_vf, s_vs, s_vb, s_mode;
   logic e_hs, e_vs, e_de, e_fs, e_err;
   logic [3*BPC-1:0] e_dat;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int rgbv(input int c);
      return (((c >> 2) & 1) * FULL << (2 * BPC)) | (((c >> 1) & 1) * FULL << BPC) | ((c & 1) * FULL);
   endfunction

   function automatic int gray(input int v);
      int g = 0;
      for (int k = 0; k < BPC; k++) g = (g << 1) | ((v >> (2 - (k % 3))) & 1);
      return g;
   endfunction

   function automatic int pat_value(input int pat, input int x, input int y);
      int col, row, bars[8];
      bars = '{7, 6, 3, 2, 5, 4, 1, 0};
      col = x / (s_ha / 8);
      row = y / (s_va / 8);
      if (col > 7) col = 7;
      if (row > 7) row = 7;
      case (pat)
         0: return rgbv(4);
         1: return rgbv(2);
         2: return rgbv(1);
         4: return rgbv(7);
         5: return (gray(7 - col) << (2 * BPC)) | (gray(7 - col) << BPC) | gray(7 - col);
         6: return ((col % 2) != (row % 2)) ? rgbv(7) : 0;
         7: return rgbv(bars[col]);
         8: return (x == 0 || x == s_ha - 1 || y == 0 || y == s_va - 1) ? rgbv(7) : 0;
         9: return ((((x - m_off) % s_ha) + s_ha) % s_ha < BAR_W) ? rgbv(7) : 0;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_run = 0; m_pix = 0; m_line = 0; m_err = 0; m_off = 0; m_pat = 0; m_fcnt = 0;
      s_ha = 0; s_hf = 0; s_hs = 0; s_hb = 0; s_va = 0; s_vf = 0; s_vs = 0; s_vb = 0; s_mode = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_dat = '0; e_fs = 1'b0; e_err = 1'b0;
   endtask

   task automatic model_load();
      s_ha = int'(h_active); s_hf = int'(h_front); s_hs = int'(h_sync); s_hb = int'(h_back);
      s_va = int'(v_active); s_vf = int'(v_front); s_vs = int'(v_sync); s_vb = int'(v_back);
      s_mode = int'(mode);
   endtask

   // Predicts the outputs after the next clock edge given the inputs currently driven
   task automatic model_step();
      int x, y, ht, vt, pat;
      bit ok;
      if (m_run != 0) begin
         x = m_pix - (s_hs + s_hb);
         y = m_line - (s_vs + s_vb);
         e_hs = !(m_pix < s_hs);
         e_vs = !(m_line < s_vs);
         e_de = (x >= 0 && x < s_ha && y >= 0 && y < s_va);
         e_fs = (m_pix == 0 && m_line == 0);
`ifdef VPG_AUTO_CYCLE_EN
         pat = m_pat;
`else
         pat = s_mode;
`endif
         e_dat = e_de ? (3*BPC)'(pat_value(pat, x, y)) : '0;
      end else begin
         e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_dat = '0; e_fs = 1'b0;
      end
      ok = (h_active >= 8) && (v_active >= 8) && (h_sync != 0) && (v_sync != 0);
      ht = s_hs + s_hb + s_ha + s_hf;
      vt = s_vs + s_vb + s_va + s_vf;
      if (m_run == 0) begin
         if (enable) begin
            if (ok) begin
               model_load();
               m_run = 1; m_pix = 0; m_line = 0; m_off = 0; m_err = 0; m_pat = 0; m_fcnt = 0;
            end else begin
               m_err = 1;
            end
         end
      end else if (m_pix == ht - 1 && m_line == vt - 1) begin
         m_pix = 0;
         m_line = 0;
         if (!enable) begin
            m_run = 0;
         end else if (ok) begin
            m_off = (m_off + 1 >= int'(h_active)) ? 0 : m_off + 1;
            model_load();
            m_err = 0;
            m_fcnt++;
            if (m_fcnt == FPM) begin
               m_fcnt = 0;
               m_pat = (m_pat + 1) % 10;
            end
         end else begin
            m_run = 0;
            m_err = 1;
         end
      end else if (m_pix == ht - 1) begin
         m_pix = 0;
         m_line++;
      end else begin
         m_pix++;
      end
      e_err = (m_err != 0);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_eq("hsync_n", o_hsync_n, e_hs);
      check_eq("vsync_n", o_vsync_n, e_vs);
      check_eq("de", o_de, e_de);
      check_eq("data", o_data, e_dat);
      check_eq("frame_start", o_frame_start, e_fs);
      check_eq("cfg_err", o_cfg_err, e_err);
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, md);
      h_active = HW'(ha); h_front = HW'(hf); h_sync = HW'(hs); h_back = HW'(hb);
      v_active = VW'(va); v_front = VW'(vf); v_sync = VW'(vs); v_back = VW'(vb);
      mode = 4'(md);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_hsync_n"}, o_hsync_n, 1);
      check_eq({pfx, "_vsync_n"}, o_vsync_n, 1);
      check_eq({pfx, "_de"}, o_de, 0);
      check_eq({pfx, "_data"}, o_data, 0);
      check_eq({pfx, "_frame_start"}, o_frame_start, 0);
      check_eq({pfx, "_cfg_err"}, o_cfg_err, 0);
   endtask

   initial begin
      int t1, t2, de_cnt, hs_low, vs_low, fs_cnt, ha;
      model_reset();
      #2 reset = 1'b0;
      #1 check_reset_outputs("rst");
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;

      // Reference timing: line 25 clk, frame 325 clk
      set_cfg(16, 2, 3, 4, 8, 1, 2, 2, 0);
      enable = 1'b1;
      t1 = -1; t2 = -1; de_cnt = 0; hs_low = 0; vs_low = 0;
      for (int i = 0; i < 800; i++) begin
         cycle();
         if (o_frame_start && t1 >= 0 && t2 < 0) t2 = i;
         if (o_frame_start && t1 < 0) t1 = i;
         if (t1 >= 0 && t2 < 0) begin
            if (o_de) de_cnt++;
            if (!o_vsync_n) vs_low++;
            if (!o_hsync_n && i < t1 + 25) hs_low++;
         end
      end
      check_eq("frame_period", t2 - t1, 325);
      check_eq("de_per_frame", de_cnt, 128);
      check_eq("hsync_low_per_line", hs_low, 3);
      check_eq("vsync_low_per_frame", vs_low, 50);

      // Colour bars with uneven band split
      set_cfg(20, 2, 3, 4, 8, 1, 2, 2, 7);
      run_n(800);

      // Mid-frame timing/mode change takes effect at the next frame
      set_cfg(16, 2, 3, 4, 8, 1, 2, 2, 0);
      run_n(400);
      for (int i = 0; i < 500 && m_line != 5; i++) cycle();
      set_cfg(32, 2, 3, 4, 8, 1, 2, 2, 1);
      run_n(900);

      // Enable dropped mid-frame: frame completes, then idle
      set_cfg(16, 2, 3, 4, 8, 1, 2, 2, 4);
      run_n(700);
      for (int i = 0; i < 400 && !(m_pix == 5 && m_line == 3); i++) cycle();
      enable = 1'b0;
      run_n(300);
      fs_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (o_frame_start) fs_cnt++;
      end
      check_eq("idle_no_frame_start", fs_cnt, 0);
      enable = 1'b1;
      run_n(60);

      // Rejected then accepted config
      enable = 1'b0;
      run_n(400);
      set_cfg(16, 2, 0, 4, 8, 1, 2, 2, 5);
      enable = 1'b1;
      run_n(10);
      check_eq("cfg_err_set", o_cfg_err, 1);
      check_eq("cfg_err_no_de", o_de, 0);
      set_cfg(16, 2, 3, 4, 8, 1, 2, 2, 5);
      fs_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (o_frame_start) fs_cnt++;
      end
      check_eq("cfg_err_clear", o_cfg_err, 0);
      check_eq("run_after_good_cfg", fs_cnt, 1);

      // Asynchronous reset mid-line
      set_cfg(16, 2, 3, 4, 8, 1, 2, 2, 8);
      run_n(437);
      reset = 1'b0;
      #1 check_reset_outputs("arst");
      model_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      run_n(400);

      // Randomized configurations, including invalid ones and enable toggling
      for (int it = 0; it < 30; it++) begin
         ha = $urandom_range(8, 40);
         set_cfg(ha, $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 3),
                 $urandom_range(8, 14), $urandom_range(0, 2), $urandom_range(1, 3),
                 $urandom_range(0, 2), $urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: h_active = HW'($urandom_range(0, 7));
               1: v_active = VW'($urandom_range(0, 7));
               2: h_sync = '0;
               default: v_sync = '0;
            endcase
         end
         enable = ($urandom_range(0, 5) != 0);
         run_n($urandom_range(100, 1200));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
